// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared definitions for the round-robin multiplier scheduler.
//   - FSM state encoding (S_IDLE, S_MUL, S_DONE) and the matching enum type
//   - clog2(): constant function sizing requester ids and iteration counters
package mult_sched_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_MUL  = S_MUL,
    ST_DONE = S_DONE
  } state_e;

  // Ceiling log2, never below 1 so a width derived from it is always legal.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/mult_sched_mult_seq.sv
// mult_seq: iterative shift-add multiplier, one partial product per clock.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load a/b and begin; ignored bits of a/b are never reused
//   a, b     : w-bit unsigned operands
//   busy     : high while iterations remain
//   fin      : high during the last iteration (the next edge completes p)
//   p        : 2w-bit product, valid once busy has fallen, held until start
module mult_seq
  import mult_sched_pkg::*;
#(
  parameter int w = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [w-1:0]   a,
  input  logic [w-1:0]   b,
  output logic           busy,
  output logic           fin,
  output logic [2*w-1:0] p
);

  localparam int CW = clog2(w);

  logic [2*w-1:0] a_q;
  logic [2*w-1:0] acc_q;
  logic [2*w-1:0] acc_d;
  logic [w-1:0]   b_q;
  logic [CW-1:0]  cnt_q;
  logic           last;

  assign last = (cnt_q == CW'(w - 1));

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_d = acc_q;
    if (b_q[cnt_q]) acc_d = acc_q + (a_q << cnt_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      a_q   <= {{w{1'b0}}, a};
      b_q   <= b;
      acc_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (last) busy <= 1'b0;
    end
  end

  assign fin = busy & last;
  assign p   = acc_q;

endmodule

// File: rtl/mult_sched.sv
// mult_sched: round-robin scheduler sharing one shift-add multiplier among n
// requesters, with a runtime-loadable ignore value that retires matching
// operations early as skipped.
//   clk, rst      : clock, asynchronous active-high reset
//   req[n]        : request lines, bit i = requester i
//   a_in, b_in    : packed operands, requester i at [i*w +: w]
//   ld, ld_val    : load a new ignore value on the edge
//   gnt[n]        : one-hot grant pulse
//   busy          : an operation is in flight
//   done          : one-cycle result pulse, qualified by skip
//   done_id, prod : winner index and 2w-bit product, held between done pulses
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int           w   = 4,
  parameter int           n   = 4,
  parameter logic [w-1:0] ign = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [n-1:0]        req,
  input  logic [n*w-1:0]      a_in,
  input  logic [n*w-1:0]      b_in,
  input  logic                ld,
  input  logic [w-1:0]        ld_val,
  output logic [n-1:0]        gnt,
  output logic                busy,
  output logic                done,
  output logic [clog2(n)-1:0] done_id,
  output logic                skip,
  output logic [2*w-1:0]      prod
);

  localparam int IW = clog2(n);

  state_e          state_q;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   sel_q;
  logic [w-1:0]    ign_q;
  logic            skip_q;

  logic [IW-1:0]   idx;
  logic [IW-1:0]   pick;
  logic [n-1:0]    onehot;
  logic            found;
  logic [w-1:0]    a_sel;
  logic [w-1:0]    b_sel;
  logic            hit_ign;
  logic            start;
  logic            mul_busy;
  logic            mul_fin;
  logic [2*w-1:0]  mul_p;

  // Round-robin: scan last_q+1, last_q+2, ... (mod n), first set bit wins.
  always_comb begin
    idx    = '0;
    pick   = '0;
    found  = 1'b0;
    onehot = '0;
    for (int k = 1; k <= n; k++) begin
      idx = IW'((int'(last_q) + k) % n);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    onehot[pick] = found;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < n; i++) begin
      if (pick == IW'(i)) begin
        a_sel = a_in[i*w +: w];
        b_sel = b_in[i*w +: w];
      end
    end
  end

  // Compared against the pre-edge ignore value, so a same-edge ld is not seen.
  assign hit_ign = (a_sel == ign_q) || (b_sel == ign_q);
  assign start   = (state_q == ST_IDLE) && found && !hit_ign;

  mult_seq #(.w(w)) u_mult (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_sel),
    .b     (b_sel),
    .busy  (mul_busy),
    .fin   (mul_fin),
    .p     (mul_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(n - 1);
      sel_q   <= '0;
      ign_q   <= ign;
      skip_q  <= 1'b0;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      skip    <= 1'b0;
      prod    <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      if (ld) ign_q <= ld_val;

      case (state_q)
        ST_IDLE: begin
          if (found) begin
            gnt     <= onehot;
            sel_q   <= pick;
            busy    <= 1'b1;
            skip_q  <= hit_ign;
            state_q <= hit_ign ? ST_DONE : ST_MUL;
          end
        end
        ST_MUL: begin
          // The core finishes its last iteration on this same edge.
          if (mul_busy && mul_fin) state_q <= ST_DONE;
        end
        ST_DONE: begin
          // Results update only here so they hold steady between done pulses.
          done    <= 1'b1;
          done_id <= sel_q;
          skip    <= skip_q;
          prod    <= skip_q ? '0 : mul_p;
          last_q  <= sel_q;
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: self-checking bench for mult_sched. A transaction-level model
// (round-robin pick, a*b product, fixed latency per operation kind) predicts
// every output each cycle; directed cases carry literal expected results; a
// second instance with w=6 covers wider operands.
module tb_mult_sched;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int W6 = 6;

  typedef struct {
    int     id;
    bit     skip;
    longint prod;
    int     lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT stimulus (driven by the requester agent)
  logic [N-1:0]   req    = '0;
  logic [N*W-1:0] a_in   = '0;
  logic [N*W-1:0] b_in   = '0;
  logic           ld     = 1'b0;
  logic [W-1:0]   ld_val = '0;
  logic [N-1:0]   gnt;
  logic           busy, done, skip;
  logic [1:0]     done_id;
  logic [2*W-1:0] prod;

  // wide DUT
  logic [1:0]      req6 = '0;
  logic [2*W6-1:0] a6   = '0;
  logic [2*W6-1:0] b6   = '0;
  logic [1:0]      gnt6;
  logic            busy6, done6, skip6;
  logic [0:0]      id6;
  logic [2*W6-1:0] prod6;

  mult_sched #(.w(W), .n(N)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .ld(ld), .ld_val(ld_val),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .skip(skip), .prod(prod)
  );

  mult_sched #(.w(W6), .n(2)) dut6 (
    .clk(clk), .rst(rst), .req(req6), .a_in(a6), .b_in(b6), .ld(1'b0), .ld_val(6'd0),
    .gnt(gnt6), .busy(busy6), .done(done6), .done_id(id6), .skip(skip6), .prod(prod6)
  );

  // ---------------- control shared from the main sequence ----------------
  int           cmd_seq [N] = '{default: 0};
  logic [W-1:0] cmd_a   [N];
  logic [W-1:0] cmd_b   [N];
  logic         man_ld  = 1'b0;
  logic [W-1:0] man_ldv = '0;
  logic         rand_mode = 1'b0;
  logic         dir_on    = 1'b1;
  logic         fin_req   = 1'b0;
  int           to_count  = 0;
  exp_t         exp_q  [$];
  exp_t         exp6_q [$];

  // ---------------- requester agent ----------------
  int           seen_seq [N] = '{default: 0};
  logic [N-1:0] pending = '0;
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  function automatic logic [W-1:0] rnd_op();
    if ($urandom_range(0, 2) == 0) return W'($urandom_range(0, 3));
    return W'($urandom_range(0, (1 << W) - 1));
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      // A granted requester drops req; in random mode it sometimes keeps it up.
      if (gnt[i] && !(rand_mode && ($urandom_range(0, 3) == 0))) pending[i] = 1'b0;
      if (cmd_seq[i] != seen_seq[i]) begin
        seen_seq[i] = cmd_seq[i];
        pending[i]  = 1'b1;
        op_a[i]     = cmd_a[i];
        op_b[i]     = cmd_b[i];
      end else if (rand_mode && !pending[i] && ($urandom_range(0, 5) == 0)) begin
        pending[i] = 1'b1;
        op_a[i]    = rnd_op();
        op_b[i]    = rnd_op();
      end
      req[i]           = pending[i];
      a_in[i*W +: W]   = op_a[i];
      b_in[i*W +: W]   = op_b[i];
    end
    if (rand_mode) begin
      ld     = ($urandom_range(0, 24) == 0);
      ld_val = W'($urandom_range(0, 3));
    end else begin
      ld     = man_ld;
      ld_val = man_ldv;
    end
  end

  // ---------------- inputs as seen by the DUT at the active edge ----------------
  logic           s_rst = 1'b1;
  logic [N-1:0]   s_req = '0;
  logic [N*W-1:0] s_a   = '0;
  logic [N*W-1:0] s_b   = '0;
  logic           s_ld  = 1'b0;
  logic [W-1:0]   s_ldv = '0;

  always @(posedge clk) begin
    s_rst <= rst;
    s_req <= req;
    s_a   <= a_in;
    s_b   <= b_in;
    s_ld  <= ld;
    s_ldv <= ld_val;
  end

  // ---------------- behavioural model ----------------
  bit           m_busy;
  int           m_owner, m_last, m_left;
  bit           m_skip;
  longint       m_res;
  logic [W-1:0] m_ign;
  logic [N-1:0] e_gnt;
  logic         e_busy, e_done, e_skip;
  logic [1:0]   e_id;
  logic [2*W-1:0] e_prod;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = N - 1; m_left = 0; m_skip = 0; m_res = 0;
    m_ign  = '0;
    e_gnt  = '0; e_busy = 0; e_done = 0; e_skip = 0; e_id = '0; e_prod = '0;
  endtask

  task automatic model_step();
    int     pick;
    bit     hit;
    longint av, bv;
    e_gnt  = '0;
    e_done = 0;
    if (!m_busy) begin
      hit  = 0;
      pick = 0;
      for (int k = 1; k <= N; k++) begin
        if (!hit && s_req[(m_last + k) % N]) begin
          hit  = 1;
          pick = (m_last + k) % N;
        end
      end
      if (hit) begin
        av      = longint'(s_a[pick*W +: W]);
        bv      = longint'(s_b[pick*W +: W]);
        m_skip  = (s_a[pick*W +: W] == m_ign) || (s_b[pick*W +: W] == m_ign);
        m_res   = m_skip ? 0 : av * bv;
        m_left  = m_skip ? 1 : W + 1;
        m_owner = pick;
        m_busy  = 1;
        e_gnt   = N'(1) << pick;
        e_busy  = 1;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        e_done = 1;
        e_id   = 2'(m_owner);
        e_skip = m_skip;
        e_prod = (2*W)'(m_res);
        m_last = m_owner;
        m_busy = 0;
        e_busy = 0;
      end
    end
    if (s_ld) m_ign = s_ldv;
  endtask

  // ---------------- compare process ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int gcyc [N] = '{default: 0};
  int g6cyc   = 0;
  int rd_idx  = 0;
  int i6      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (cyc > 60000) begin
      $display("FAIL watchdog: cycle %0d exceeded, expected finish", cyc);
      $fatal(1, "watchdog");
    end
    if (s_rst) model_reset();
    else       model_step();

    check("gnt",     64'(gnt),     64'(e_gnt));
    check("busy",    64'(busy),    64'(e_busy));
    check("done",    64'(done),    64'(e_done));
    check("done_id", 64'(done_id), 64'(e_id));
    check("skip",    64'(skip),    64'(e_skip));
    check("prod",    64'(prod),    64'(e_prod));

    for (int i = 0; i < N; i++) if (gnt[i]) gcyc[i] = cyc;
    if (done && dir_on) begin
      if (rd_idx < exp_q.size()) begin
        check("lit_id",   64'(done_id), 64'(exp_q[rd_idx].id));
        check("lit_skip", 64'(skip),    64'(exp_q[rd_idx].skip));
        check("lit_prod", 64'(prod),    64'(exp_q[rd_idx].prod));
        check("lit_lat",  64'(cyc - gcyc[done_id]), 64'(exp_q[rd_idx].lat));
      end else begin
        check("lit_extra_done", 64'(rd_idx), 64'(exp_q.size()));
      end
      rd_idx++;
    end

    if (gnt6 != 2'b00) g6cyc = cyc;
    if (done6) begin
      if (i6 < exp6_q.size()) begin
        check("w6_prod", 64'(prod6),       64'(exp6_q[i6].prod));
        check("w6_skip", 64'(skip6),       64'(exp6_q[i6].skip));
        check("w6_id",   64'(id6),         64'(exp6_q[i6].id));
        check("w6_lat",  64'(cyc - g6cyc), 64'(exp6_q[i6].lat));
      end else begin
        check("w6_extra_done", 64'(i6), 64'(exp6_q.size()));
      end
      i6++;
    end

    if (fin_req) begin
      check("timeouts", 64'(to_count), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // ---------------- main sequence ----------------
  task automatic issue(input int i, input int a, input int b);
    cmd_a[i]   = W'(a);
    cmd_b[i]   = W'(b);
    cmd_seq[i] = cmd_seq[i] + 1;
  endtask

  task automatic expect_done(input int id, input bit sk, input longint p, input int lat);
    exp_q.push_back('{id, sk, p, lat});
  endtask

  task automatic wait_items(input int budget);
    int k = 0;
    while (rd_idx < exp_q.size() && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (rd_idx < exp_q.size()) to_count++;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_ld(input int v);
    @(negedge clk);
    man_ldv = W'(v);
    man_ld  = 1'b1;
    @(negedge clk);
    man_ld  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run6(input int a, input int b, input longint p);
    int k;
    exp6_q.push_back('{0, 1'b0, p, W6 + 1});
    @(negedge clk);
    a6[W6-1:0] = W6'(a);
    b6[W6-1:0] = W6'(b);
    req6       = 2'b01;
    k = 0;
    while (!gnt6[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!gnt6[0]) to_count++;
    req6 = 2'b00;
    k = 0;
    while (i6 < exp6_q.size() && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (i6 < exp6_q.size()) to_count++;
  endtask

  initial begin
    int k;
    int a, b;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single computed operation
    issue(0, 5, 10);
    expect_done(0, 0, 50, 5);
    wait_items(40);

    // all four at once, served 0,1,2,3 after reset
    do_reset();
    issue(0, 3, 4); issue(1, 15, 15); issue(2, 2, 7); issue(3, 6, 9);
    expect_done(0, 0, 12, 5);
    expect_done(1, 0, 225, 5);
    expect_done(2, 0, 14, 5);
    expect_done(3, 0, 54, 5);
    wait_items(80);

    // ignore value: reset default, then loaded 7
    do_reset();
    issue(0, 0, 9);
    expect_done(0, 1, 0, 1);
    wait_items(20);
    pulse_ld(7);
    issue(0, 7, 3);
    expect_done(0, 1, 0, 1);
    wait_items(20);
    issue(0, 0, 9);
    expect_done(0, 0, 0, 5);
    wait_items(20);

    // round-robin wrap past the last winner
    do_reset();
    issue(2, 2, 3);
    expect_done(2, 0, 6, 5);
    wait_items(20);
    issue(0, 1, 1); issue(2, 2, 2);
    expect_done(0, 0, 1, 5);
    expect_done(2, 0, 4, 5);
    wait_items(40);

    // reset mid-operation aborts it and restores the ignore value
    do_reset();
    pulse_ld(7);
    issue(0, 5, 5);
    k = 0;
    while (!gnt[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!gnt[0]) to_count++;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(0, 7, 3);
    expect_done(0, 0, 21, 5);
    wait_items(30);

    // randomized traffic against the model
    dir_on    = 1'b0;
    rand_mode = 1'b1;
    repeat (4000) @(negedge clk);
    rand_mode = 1'b0;
    k = 0;
    while ((req != '0 || busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (req != '0 || busy) to_count++;

    // wider operands
    run6(63, 63, 3969);
    run6(63, 13, 819);
    for (int t = 0; t < 4; t++) begin
      a = $urandom_range(1, 63);
      b = $urandom_range(1, 63);
      run6(a, b, longint'(a) * longint'(b));
    end

    fin_req = 1'b1;
    repeat (4) @(negedge clk);
  end

endmodule
